// File: rtl/s_pl_pkg.sv
// Shared types for the s_pl_rslice register slice: FSM state encoding and width.
package s_pl_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b10
   } s_pl_state_t;

endpackage

// File: rtl/s_pl_reg_en.sv
// Enable-gated SIZE-bit register with synchronous active-low reset to RST_VAL.
module s_pl_reg_en #(
   parameter int              SIZE    = 8,
   parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_en,
   input  logic [SIZE-1:0] i_d,
   output logic [SIZE-1:0] o_q
);

   logic [SIZE-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= RST_VAL;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/s_pl_rslice.sv
// Valid/ready register slice with a one-entry skid buffer; irdy, ovld and odat are registered.
// Optional S_PL_RSLICE_FLUSH_EN adds a flush input that empties the slice.
module s_pl_rslice
   import s_pl_pkg::*;
#(
   parameter int              SIZE    = 8,
   parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
   input  logic            clk,
   input  logic            rst_n,
`ifdef S_PL_RSLICE_FLUSH_EN
   input  logic            flush,
`endif
   input  logic            ivld,
   output logic            irdy,
   input  logic [SIZE-1:0] idat,
   output logic            ovld,
   input  logic            ordy,
   output logic [SIZE-1:0] odat,
   output s_pl_state_t     o_dbg_state
);

   // Handshake: a word moves on any posedge where valid and ready are both high;
   // a producer holds valid/data until accepted, and ovld/odat never change while ovld & ~ordy.

   s_pl_state_t     r_state;
   s_pl_state_t     w_nxt;
   logic            r_irdy;
   logic            r_ovld;
   logic            w_in_fire;
   logic            w_flush;
   logic            w_main_en;
   logic            w_skid_en;
   logic [SIZE-1:0] w_main_d;
   logic [SIZE-1:0] w_main_q;
   logic [SIZE-1:0] w_sdat;

`ifdef S_PL_RSLICE_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   always_comb begin
      w_nxt     = r_state;
      w_main_en = 1'b0;
      w_skid_en = 1'b0;
      w_main_d  = idat;
      w_in_fire = ivld & r_irdy;
      if (w_flush) begin
         w_nxt = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_fire) begin
                  w_main_en = 1'b1;
                  w_nxt     = BUSY;
               end
            end
            BUSY: begin
               if (w_in_fire && ordy) begin
                  w_main_en = 1'b1;
               end else if (w_in_fire) begin
                  // irdy is one cycle late, so the word that arrives during the stall lands in skid
                  w_skid_en = 1'b1;
                  w_nxt     = FULL;
               end else if (ordy) begin
                  w_nxt = EMPTY;
               end
            end
            FULL: begin
               if (ordy) begin
                  w_main_en = 1'b1;
                  w_main_d  = w_sdat;
                  w_nxt     = BUSY;
               end
            end
            default: begin
               w_nxt = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= EMPTY;
         r_ovld  <= 1'b0;
         r_irdy  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_ovld  <= (w_nxt != EMPTY);
         r_irdy  <= (w_nxt != FULL);
      end
   end

   s_pl_reg_en #(
      .SIZE    (SIZE),
      .RST_VAL (RST_VAL)
   ) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_main_en),
      .i_d   (w_main_d),
      .o_q   (w_main_q)
   );

   s_pl_reg_en #(
      .SIZE    (SIZE),
      .RST_VAL (RST_VAL)
   ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_skid_en),
      .i_d   (idat),
      .o_q   (w_sdat)
   );

   assign irdy        = r_irdy;
   assign ovld        = r_ovld;
   assign odat        = w_main_q;
   assign o_dbg_state = r_state;

endmodule

// File: doc/s_pl_rslice.md
Name: s_pl_rslice

Overview:
- Synchronous valid/ready pipeline register slice with a one-entry skid buffer.
- Unlike a plain pipeline register, it honours downstream backpressure and registers the ready path going back upstream, so the consumer end can stall without combinational ready chains.
- Sits between any two valid/ready stages; full throughput of one word per cycle.

Parameters:
- SIZE, 8, data width in bits.
- RST_VAL, {SIZE{1'b0}}, reset value of odat and the skid register.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: synchronous, active-low; clock clk.
- ivld  input  1  upstream data valid.
- irdy  output  1  upstream ready; registered.
- idat  input  SIZE  upstream data.
- ovld  output  1  downstream data valid; registered.
- ordy  input  1  downstream ready.
- odat  output  SIZE  downstream data; registered.

Behaviour:
- Transfers: input on ivld&irdy at posedge clk; output on ovld&ordy at posedge clk.
- Storage: main register (drives odat) and skid register (sdat).
- States (2-bit):
  - EMPTY: ovld=0, irdy=1.
  - BUSY: ovld=1, irdy=1, main holds the word.
  - FULL: ovld=1, irdy=0, main and skid both hold words.
- Transitions:
  - EMPTY, ivld: main<=idat, go to BUSY. Otherwise stay.
  - BUSY, ivld&ordy: main<=idat, stay in BUSY.
  - BUSY, ivld&~ordy: sdat<=idat, go to FULL.
  - BUSY, ~ivld&ordy: go to EMPTY; main keeps its stale value.
  - BUSY, ~ivld&~ordy: hold.
  - FULL, ordy: main<=sdat, go to BUSY. ivld is ignored because irdy=0.
  - FULL, ~ordy: hold; odat and sdat stable.
- Latency: a word accepted at edge N appears on odat/ovld after edge N when the slice is EMPTY. Otherwise it waits behind older words.
- Throughput: one word per cycle sustained with ordy=1.
- Ordering: strict FIFO, no loss, no duplication. Capacity is 2 words.
- Upstream protocol: once ivld=1, upstream holds ivld and idat until accepted. The slice does not depend on this for correctness; the 1-cycle irdy lag is covered by the skid register.
- Downstream guarantee: ovld/odat stable while ovld&~ordy.
- Reset (rst_n=0 at edge):
  - State goes to EMPTY; ovld=0; odat=RST_VAL; sdat=RST_VAL.
  - irdy=0 while rst_n is sampled low. irdy=1 from the first edge that samples rst_n=1.
- Reset mid-operation: any held words are discarded with no drain. Input is ignored while rst_n=0.
- Illegal state encoding goes to EMPTY.

Optional Feature:
- Macro S_PL_RSLICE_FLUSH_EN.
- Defined: adds input port flush (1 bit). flush=1 at an edge discards all held words: state goes to EMPTY, ovld=0, odat and sdat keep their values, and any input handshake in the same cycle is dropped. irdy stays 1 during flush unless in reset. Priority order: rst_n first, then flush, then normal operation.
- Undefined: no flush port; behaviour exactly as above.

Decomposition:
- Package s_pl_pkg holds:
  - the state typedef (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10);
  - a localparam for the state width.
- One natural sub-module: s_pl_reg_en, an enable-gated SIZE-bit synchronous register with RST_VAL. It is instantiated for main and for skid. Control FSM stays in the top.

Test Plan:
- Reset: hold rst_n=0 three cycles with ivld=1, idat=8'hAA. Required: ovld=0, odat=8'h00, irdy=0. Release reset: irdy=1 after the next edge and 8'hAA is accepted.
- Streaming: ordy=1, send 8'h01..8'h10 back-to-back. Required: ovld high continuously from the cycle after the first accept, odat=01..10 in order, irdy never 0.
- Backpressure: stream 8'h20, 8'h21, 8'h22 and drop ordy after 8'h20 is shown. Required: FULL with odat=20, sdat=21, irdy=0, 8'h22 held upstream. Raise ordy: outputs 20, 21, 22 with no loss or duplicate.
- Random: random ivld/ordy over 10k cycles with a scoreboard. Required: in-order, lossless output; ovld/odat stable whenever ovld&~ordy.
- Reset while FULL: assert rst_n=0. Required: the next edge gives ovld=0 and odat=8'h00; the held words never appear.
- Flush (S_PL_RSLICE_FLUSH_EN): assert flush while FULL with ivld=1, idat=8'h55. Required: ovld=0, EMPTY, and 8'h55 is not captured.
